// File: rtl/clock_divider_multi_if.sv
// Control/status bundle for clock_divider_multi: per-channel half-period, load,
// enable, global sync, and the divided outputs.
`timescale 1ns/1ps
interface clock_divider_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
);
    logic [CHANNELS*CNT_W-1:0] half_period;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS-1:0]       enable;
    logic                      sync_in;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       clk_not_out;
    logic [CHANNELS-1:0]       tick;

    modport master (
        output half_period, load, enable, sync_in,
        input  clk_out, clk_not_out, tick
    );

    modport slave (
        input  half_period, load, enable, sync_in,
        output clk_out, clk_not_out, tick
    );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock/strobe divider on the 4 MHz system clock.
// Define CLOCK_DIV_TICK_EN to build the per-channel rising-edge tick; otherwise tick is tied to 0.
`timescale 1ns/1ps
module clock_divider_multi #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 10000
) (
    input  logic                  clk_4mhz,
    input  logic                  reset,
    clock_divider_multi_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN_LO = 2'd1,
        ST_RUN_HI = 2'd2
    } state_t;

    // A half-period of 0 behaves as 1, so the reload value is max(hp,1)-1.
    function automatic logic [CNT_W-1:0] reloadOf(input logic [CNT_W-1:0] hp);
        return (hp == '0) ? '0 : hp - 1'b1;
    endfunction

    localparam logic [CNT_W-1:0] RST_HP = CNT_W'(DEFAULT_HALF);

    logic [CHANNELS-1:0] w_clkOut;
    logic [CHANNELS-1:0] w_clkNotOut;
    logic [CHANNELS-1:0] w_tick;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           r_state;
        state_t           w_stateNext;
        logic [CNT_W-1:0] r_hp;
        logic [CNT_W-1:0] r_pend;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pendValid;
        logic             r_clkOut;
        logic             r_clkNot;
        logic [CNT_W-1:0] w_hpNext;
        logic [CNT_W-1:0] w_pendNext;
        logic [CNT_W-1:0] w_cntNext;
        logic             w_pendValidNext;
        logic             w_outNext;
        logic [CNT_W-1:0] w_loadVal;
        logic             w_en;
        logic             w_load;

        assign w_loadVal = bus.half_period[g*CNT_W +: CNT_W];
        assign w_en      = bus.enable[g];
        assign w_load    = bus.load[g];

        // Priority: disable, then sync restart, then normal counting.
        always_comb begin
            w_stateNext     = r_state;
            w_hpNext        = r_hp;
            w_pendNext      = r_pend;
            w_pendValidNext = r_pendValid;
            w_cntNext       = r_cnt;

            if (!w_en) begin
                w_stateNext = ST_IDLE;
                if (w_load) begin
                    w_hpNext        = w_loadVal;
                    w_pendValidNext = 1'b0;
                end
                w_cntNext = reloadOf(w_hpNext);
            end else if (bus.sync_in) begin
                if (w_load) begin
                    w_hpNext = w_loadVal;
                end else if (r_pendValid) begin
                    w_hpNext = r_pend;
                end
                w_pendValidNext = 1'b0;
                w_cntNext       = reloadOf(w_hpNext);
                w_stateNext     = ST_RUN_LO;
            end else begin
                if (w_load) begin
                    w_pendNext      = w_loadVal;
                    w_pendValidNext = 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        w_stateNext = ST_RUN_LO;
                    end
                    default: begin
                        if (r_cnt == '0) begin
                            // A pending value takes effect only here, at a half-period boundary.
                            if (r_pendValid) begin
                                w_hpNext        = r_pend;
                                w_pendValidNext = w_load;
                            end
                            w_cntNext   = reloadOf(w_hpNext);
                            w_stateNext = (r_state == ST_RUN_HI) ? ST_RUN_LO : ST_RUN_HI;
                        end else begin
                            w_cntNext = r_cnt - 1'b1;
                        end
                    end
                endcase
            end

            w_outNext = (w_stateNext == ST_RUN_HI);
        end

        always_ff @(posedge clk_4mhz or negedge reset) begin
            if (!reset) begin
                r_state     <= ST_IDLE;
                r_hp        <= RST_HP;
                r_pend      <= '0;
                r_pendValid <= 1'b0;
                r_cnt       <= reloadOf(RST_HP);
                r_clkOut    <= 1'b0;
                r_clkNot    <= 1'b1;
            end else begin
                r_state     <= w_stateNext;
                r_hp        <= w_hpNext;
                r_pend      <= w_pendNext;
                r_pendValid <= w_pendValidNext;
                r_cnt       <= w_cntNext;
                r_clkOut    <= w_outNext;
                r_clkNot    <= ~w_outNext;
            end
        end

        assign w_clkOut[g]    = r_clkOut;
        assign w_clkNotOut[g] = r_clkNot;

`ifdef CLOCK_DIV_TICK_EN
        logic r_tick;

        always_ff @(posedge clk_4mhz or negedge reset) begin
            if (!reset) begin
                r_tick <= 1'b0;
            end else begin
                r_tick <= w_outNext & ~r_clkOut;
            end
        end

        assign w_tick[g] = r_tick;
`else
        assign w_tick[g] = 1'b0;
`endif
    end

    assign bus.clk_out     = w_clkOut;
    assign bus.clk_not_out = w_clkNotOut;
    assign bus.tick        = w_tick;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: expected rise cycles are queued as
// stimulus is applied and compared as each channel's clk_out rises.
`timescale 1ns/1ps
module tb_clock_divider_multi;

    localparam int CH = 4;
    localparam int CW = 16;
    localparam int DH = 10000;
`ifdef CLOCK_DIV_TICK_EN
    localparam logic TICK_ON = 1'b1;
`else
    localparam logic TICK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstN;
    always #125 clk = ~clk;

    clock_divider_multi_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

    clock_divider_multi #(
        .CHANNELS(CH),
        .CNT_W(CW),
        .DEFAULT_HALF(DH)
    ) dut (
        .clk_4mhz(clk),
        .reset(rstN),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string tag;
        int    ch;
        int    at;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [CH*CW-1:0] hpv = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic setHp(input int ch, input int val);
        hpv[ch*CW +: CW] = CW'(val);
    endtask

    task automatic pushRise(input string tag, input int ch, input int at);
        exp_t e;
        e.tag = tag;
        e.ch  = ch;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Drive at a falling edge; k is the rising edge that samples it. Returns one cycle later.
    task automatic applyStimulus(input logic [CH-1:0] en, input logic [CH-1:0] ld,
                                 input logic sync, output int k);
        bus.enable      = en;
        bus.load        = ld;
        bus.sync_in     = sync;
        bus.half_period = hpv;
        k = cyc + 1;
        @(negedge clk);
        bus.load    = '0;
        bus.sync_in = 1'b0;
    endtask

    task automatic waitRise(input int ch, input int budget, output int at);
        logic prev;
        prev = bus.clk_out[ch];
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.clk_out[ch] && !prev) begin
                at = cyc;
                return;
            end
            prev = bus.clk_out[ch];
        end
    endtask

    task automatic drainRises();
        exp_t e;
        int   got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            waitRise(e.ch, 2 * DH + 20, got);
            checkOutput(e.tag, got, e.at);
            if (got >= 0) checkOutput({e.tag, "_tick"}, bus.tick[e.ch], TICK_ON);
        end
    endtask

    // Continuous watch of the complementary output and the tick strobe.
    logic [CH-1:0] prevOut = '0;
    int invErr  = 0;
    int tickErr = 0;
    always @(negedge clk) begin
        if (!rstN) begin
            prevOut <= '0;
        end else begin
            if (bus.clk_not_out !== ~bus.clk_out) invErr <= invErr + 1;
            if (bus.tick !== (TICK_ON ? (bus.clk_out & ~prevOut) : '0)) tickErr <= tickErr + 1;
            prevOut <= bus.clk_out;
        end
    end

    initial begin
        int k;
        int got;

        rstN            = 1'b0;
        bus.enable      = 4'b0001;
        bus.load        = '0;
        bus.sync_in     = 1'b0;
        bus.half_period = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_clk_out", bus.clk_out, 0);
        checkOutput("rst_clk_not_out", bus.clk_not_out, 4'hF);
        checkOutput("rst_tick", bus.tick, 0);

        // Default 5 ms timebase on channel 0.
        rstN = 1'b1;
        k = cyc + 1;
        pushRise("ch0_first_rise", 0, k + DH);
        pushRise("ch0_second_rise", 0, k + 3 * DH);
        drainRises();
        checkOutput("idle_ch_out", bus.clk_out[3:1], 0);
        checkOutput("idle_ch_not_out", bus.clk_not_out[3:1], 3'b111);

        // Channel 1: preset 5 while disabled, then reprogram to 3 mid-high-phase.
        setHp(1, 5);
        applyStimulus(4'b0001, 4'b0010, 1'b0, k);
        applyStimulus(4'b0011, 4'b0000, 1'b0, k);
        pushRise("ch1_old_rise", 1, k + 5);
        drainRises();
        setHp(1, 3);
        applyStimulus(4'b0011, 4'b0010, 1'b0, got);
        pushRise("ch1_new_rise1", 1, k + 13);
        pushRise("ch1_new_rise2", 1, k + 19);
        drainRises();
        @(negedge clk);
        checkOutput("ch1_tick_width", bus.tick[1], 0);

        // Channel 2: half-period 0 and 1 both divide by 2.
        setHp(2, 0);
        applyStimulus(4'b0011, 4'b0100, 1'b0, k);
        applyStimulus(4'b0111, 4'b0000, 1'b0, k);
        pushRise("ch2_hp0_rise1", 2, k + 1);
        pushRise("ch2_hp0_rise2", 2, k + 3);
        drainRises();
        setHp(2, 1);
        applyStimulus(4'b0011, 4'b0100, 1'b0, k);
        applyStimulus(4'b0111, 4'b0000, 1'b0, k);
        pushRise("ch2_hp1_rise1", 2, k + 1);
        pushRise("ch2_hp1_rise2", 2, k + 3);
        drainRises();

        // All channels 5/7/9/11, then a global sync.
        setHp(0, 5);
        setHp(1, 7);
        setHp(2, 9);
        setHp(3, 11);
        applyStimulus(4'b0000, 4'b1111, 1'b0, k);
        applyStimulus(4'b1111, 4'b0000, 1'b0, k);
        repeat (12) @(negedge clk);
        applyStimulus(4'b1111, 4'b0000, 1'b1, k);
        checkOutput("sync_clk_out", bus.clk_out, 0);
        checkOutput("sync_clk_not_out", bus.clk_not_out, 4'hF);
        pushRise("sync_ch0_rise", 0, k + 5);
        pushRise("sync_ch1_rise", 1, k + 7);
        pushRise("sync_ch2_rise", 2, k + 9);
        pushRise("sync_ch3_rise", 3, k + 11);
        drainRises();

        // Load and sync together on channel 0: the restart uses the new value.
        setHp(0, 4);
        applyStimulus(4'b1111, 4'b0001, 1'b1, k);
        checkOutput("ldsync_clk_out", bus.clk_out, 0);
        pushRise("ldsync_ch0_rise", 0, k + 4);
        pushRise("ldsync_ch1_rise", 1, k + 7);
        pushRise("ldsync_ch0_rise2", 0, k + 12);
        drainRises();

        // Channel 0 is high here; dropping enable forces it low one cycle later.
        applyStimulus(4'b1110, 4'b0000, 1'b0, k);
        checkOutput("endrop_clk_out", bus.clk_out[0], 0);
        checkOutput("endrop_clk_not_out", bus.clk_not_out[0], 1);

        // Asynchronous reset between clock edges.
        waitRise(1, 40, got);
        checkOutput("ch1_running", got > 0, 1);
        #20;
        rstN = 1'b0;
        #20;
        checkOutput("async_rst_clk_out", bus.clk_out, 0);
        checkOutput("async_rst_clk_not_out", bus.clk_not_out, 4'hF);
        checkOutput("async_rst_tick", bus.tick, 0);
        bus.enable = 4'b0001;
        @(negedge clk);
        rstN = 1'b1;
        k = cyc + 1;
        pushRise("post_rst_ch0_rise", 0, k + DH);
        drainRises();
        checkOutput("post_rst_others", bus.clk_out[3:1], 0);

        checkOutput("not_inverse_errs", invErr, 0);
        checkOutput("tick_errs", tickErr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised multi-channel clock/strobe generator running from the 4 MHz system clock. It generalises the fixed 5 ms clock block: N independent channels, each with a runtime-programmable half-period, per-channel enable, and complementary outputs. It also provides a global phase-sync input and an optional single-cycle tick. The 5 ms timebase and the other slow timing strobes feeding measurement and display logic come from this block.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `CNT_W`, 16: half-period counter width in bits.
- `DEFAULT_HALF`, 10000: half-period loaded at reset, in `clk_4mhz` cycles. Gives a 5 ms period at 4 MHz.
- `clk_4mhz` input, 1: system clock, 4 MHz, rising-edge.
- `reset` input, 1: asynchronous, active-low reset.
- `half_period` input, CHANNELS*CNT_W: per-channel new half-period. Channel i uses bits [i*CNT_W +: CNT_W].
- `load` input, CHANNELS: one-cycle pulse per channel; latches that channel's `half_period` into its shadow register.
- `enable` input, CHANNELS: level; channel i runs while high.
- `sync_in` input, 1: one-cycle pulse; restarts all enabled channels in phase.
- `clk_out` output, CHANNELS: divided square wave per channel.
- `clk_not_out` output, CHANNELS: registered complement of `clk_out`.
- `tick` output, CHANNELS: one-cycle strobe on each `clk_out` rising edge.

## Operation
- Each channel has three registers:
  - `hp_reg`: active half-period (CNT_W bits).
  - `pend_reg` with a `pend_valid` flag.
  - `cnt`: down-counter.
- Effective half-period H = max(`hp_reg`, 1). A value of 0 is clamped to 1, which gives clk/2.
- Running (enable=1): `cnt` decrements each cycle. When `cnt`==0:
  - `clk_out` toggles;
  - `cnt` reloads to H-1;
  - if `pend_valid` is set, `hp_reg`←`pend_reg` first and the reload uses the new value. This keeps half-period changes glitch-free at a boundary.
- Output period is 2·H cycles with 50 % duty.
- `load` while running sets `pend_reg`/`pend_valid`. A second `load` before the boundary overwrites `pend_reg`; the last one wins.
- `load` while disabled writes `hp_reg` directly; `pend_valid` is cleared.
- Disabled (enable=0), on the next clock:
  - `cnt`←H-1, `clk_out`←0, `clk_not_out`←1, `tick`←0;
  - the channel holds there.
- Channel states: IDLE (disabled), RUN_LO, RUN_HI.
  - IDLE→RUN_LO when enable rises.
  - RUN_LO↔RUN_HI at each `cnt`==0.
  - Any state→IDLE when enable=0.
- `sync_in` applies to every enabled channel:
  - applies any pending load;
  - sets `cnt`←H-1 and `clk_out`←0 (RUN_LO).
  - `sync_in` has priority over a simultaneous terminal count.
- `load` and `sync_in` in the same cycle: the new value is used immediately for the restart.
- `tick[i]` is high for exactly the cycle in which `clk_out[i]` first reads 1.

## Timing
- Reset values (asynchronous):
  - `hp_reg`=DEFAULT_HALF, `cnt`=DEFAULT_HALF-1, `pend_valid`=0;
  - `clk_out`=0, `clk_not_out`=all ones, `tick`=0.
- All outputs are registered. There is no combinational path from any input to any output.
- `enable` rise at edge k: first `clk_out` rise visible after edge k+H, then a toggle every H cycles.
- `sync_in` sampled at edge k: `clk_out`=0 after edge k, first rise after edge k+H.
- A deasserted `enable` takes effect one cycle later.
- Reset deassertion mid-period restarts every channel from its reset values. No partial state survives.

## Configuration
- `CLOCK_DIV_TICK_EN` defined: `tick` is generated as specified.
- `CLOCK_DIV_TICK_EN` undefined: the `tick` port remains but is tied to 0, and the edge-detect registers are not built.

## Test plan
- Reset release with enable=4'b0001 and default half-period:
  - `clk_out[0]` rises 10000 cycles after release; period 20000 cycles (5 ms).
  - `clk_not_out[0]` is always the inverse.
  - Other channels stay 0/1.
- Ch1 `load` half_period=3 while running:
  - the old half-period completes unchanged;
  - from the next boundary, toggles every 3 cycles (period 6).
  - `tick[1]` is one cycle wide at each rise.
- Ch2 half_period=0 and half_period=1: both give `clk_out` toggling every cycle (period 2).
- Channels 0..3 with half-periods 5, 7, 9, 11 running, then `sync_in`:
  - all `clk_out`=0 the next cycle;
  - rises at +5, +7, +9, +11 cycles.
- `load` and `sync_in` together on ch0 with value 4: the restart uses 4, first rise after 4 cycles.
- `enable` dropped mid-high-phase: `clk_out`=0 next cycle.
- `reset` asserted asynchronously mid-count: all outputs reach reset values without waiting for a clock edge.
- Build without `CLOCK_DIV_TICK_EN`: `tick` stays 0 for all channels.
